// File: rtl/spi_levi_pkg.sv
// spi_levi_pkg: shared command, error-code and state definitions for the SPI phase path
package spi_levi_pkg;
    localparam logic [7:0] CMD_PHASE  = 8'hA5;
    localparam logic [1:0] ERR_BADCMD = 2'd0;
    localparam logic [1:0] ERR_RANGE  = 2'd1;
    localparam logic [1:0] ERR_CSUM   = 2'd2;
    localparam logic [1:0] ERR_ABORT  = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs
module sync_2ff #(
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= {RST_VAL, RST_VAL};
        else     {q, m} <= {m, d};
endmodule

// File: rtl/spi_phase_ctrl.sv
// spi_phase_ctrl: parses SPI phase-update frames into shadow-bank writes and a checked commit
module spi_phase_ctrl
    import spi_levi_pkg::*;
#(
    parameter int NUM_CH = 64,
    parameter int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ss,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          commit,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          busy
);
    localparam logic [8:0] NCH = 9'(NUM_CH);
    logic ss_s;
    state_t state, proc, nxt;
    logic [7:0] idx, idx_n, rem, rem_n, acc, acc_n;
    logic wr_n, commit_n, err_n, busy_n;
    logic [1:0] code_n;
    // Deselected out of reset so a half-seen frame never starts parsing
    sync_2ff #(.W(1), .RST_VAL(1'b1)) u_ss_sync (.clk(clk), .rst(rst), .d(ss), .q(ss_s));
    always_comb begin
        proc = state;
        idx_n = idx;
        rem_n = rem;
        wr_n = 1'b0;
        commit_n = 1'b0;
        err_n = 1'b0;
        code_n = err_code;
        busy_n = busy;
        if (byte_valid) begin
            case (state)
                S_IDLE: if (!ss_s) begin
                    if (byte_data == CMD_PHASE) begin
                        proc = S_ADDR;
                        busy_n = 1'b1;
                    end else begin
                        proc = S_ERR;
                        err_n = 1'b1;
                        code_n = ERR_BADCMD;
                    end
                end
                S_ADDR: begin
                    idx_n = byte_data;
                    proc = S_COUNT;
                end
                S_COUNT: if (byte_data == '0 || {1'b0, idx} >= NCH || {1'b0, idx} + {1'b0, byte_data} > NCH) begin
                    proc = S_ERR;
                    err_n = 1'b1;
                    code_n = ERR_RANGE;
                end else begin
                    rem_n = byte_data;
                    proc = S_DATA;
                end
                S_DATA: begin
                    wr_n = 1'b1;
                    idx_n = idx + 8'd1;
                    rem_n = rem - 8'd1;
                    proc = (rem == 8'd1) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    proc = S_DONE;
                    commit_n = (byte_data == acc);
                    err_n = (byte_data != acc);
                    code_n = (byte_data != acc) ? ERR_CSUM : err_code;
                end
                default: ;
            endcase
        end
        // The byte is consumed first; deselect then acts on the state it produced
        nxt = ss_s ? S_IDLE : proc;
        if (ss_s && proc inside {S_ADDR, S_COUNT, S_DATA, S_CSUM}) begin
            err_n = 1'b1;
            code_n = ERR_ABORT;
        end
        busy_n = (nxt == S_IDLE) ? 1'b0 : busy_n;
        acc_n = (nxt == S_IDLE) ? 8'h00 :
                (byte_valid && state inside {S_IDLE, S_ADDR, S_COUNT, S_DATA}) ? acc ^ byte_data : acc;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            idx <= '0;
            rem <= '0;
            acc <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            commit <= 1'b0;
            frame_err <= 1'b0;
            err_code <= ERR_BADCMD;
            busy <= 1'b0;
        end else begin
            state <= nxt;
            idx <= idx_n;
            rem <= rem_n;
            acc <= acc_n;
            wr_en <= wr_n;
            wr_addr <= wr_n ? idx[AW-1:0] : wr_addr;
            wr_data <= wr_n ? byte_data : wr_data;
            commit <= commit_n;
            frame_err <= err_n;
            err_code <= code_n;
            busy <= busy_n;
        end
endmodule

// File: tb/tb_spi_phase_ctrl.sv
// tb_spi_phase_ctrl: table, hand-sequence and randomized frame checks against a frame-level model
module tb_spi_phase_ctrl;
    localparam int NUM_CH = 64;
    localparam int AW = 6;
    typedef logic [7:0] frame_t [20];
    typedef struct {
        logic [95:0] bytes;
        int len;
        int nwr;
        int cm;
        int he;
        logic [1:0] ec;
        logic [15:0] w0;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, ss = 1'b1, byte_valid = 1'b0;
    logic [7:0] byte_data = '0;
    logic wr_en, commit, frame_err, busy;
    logic [AW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] err_code;
    int tests = 0, fails = 0;
    logic [15:0] got_q[$], exp_q[$];
    int n_commit = 0, n_err = 0;
    logic [1:0] last_code = '0;
    bit excl_bad = 0;
    vec_t tbl[10];
    frame_t fb;
    spi_phase_ctrl #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .ss(ss), .byte_valid(byte_valid), .byte_data(byte_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (wr_en) got_q.push_back({8'(wr_addr), wr_data});
        if (commit) n_commit++;
        if (frame_err) begin
            n_err++;
            last_code = err_code;
        end
        if ((wr_en && commit) || (commit && frame_err)) excl_bad = 1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b, output logic o_wr, output logic o_cm, output logic o_er);
        byte_valid = 1'b1;
        byte_data = b;
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        o_wr = wr_en;
        o_cm = commit;
        o_er = frame_err;
    endtask
    task automatic open_frame();
        ss = 1'b0;
        repeat (3) @(negedge clk);
        got_q.delete();
        n_commit = 0;
        n_err = 0;
        excl_bad = 0;
    endtask
    task automatic run_frame(input frame_t f, input int len);
        logic a, b, c;
        open_frame();
        for (int i = 0; i < len; i++) send_byte(f[i], a, b, c);
        ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask
    task automatic check_frame(input string nm, input int nwr, input int cm, input int he, input logic [1:0] ec);
        chk({nm, ".nwr"}, got_q.size(), nwr);
        chk({nm, ".commit"}, n_commit, cm);
        chk({nm, ".ferr"}, n_err, he);
        if (he != 0) chk({nm, ".code"}, last_code, ec);
        chk({nm, ".excl"}, excl_bad, 0);
        chk({nm, ".busy"}, busy, 0);
    endtask
    // Frame-level reference: decides the outcome straight from the frame format rules
    task automatic model(input frame_t f, input int len, output int nwr, output int cm, output int he, output logic [1:0] ec);
        int a, c;
        logic [7:0] x;
        nwr = 0; cm = 0; he = 0; ec = 0;
        exp_q.delete();
        if (len == 0) return;
        if (f[0] != 8'hA5) begin he = 1; ec = 0; return; end
        if (len < 3) begin he = 1; ec = 3; return; end
        a = int'(f[1]);
        c = int'(f[2]);
        if (c == 0 || a >= NUM_CH || a + c > NUM_CH) begin he = 1; ec = 1; return; end
        for (int i = 0; i < c && i < len - 3; i++) exp_q.push_back({8'(a + i), f[3+i]});
        nwr = exp_q.size();
        if (len < c + 4) begin he = 1; ec = 3; return; end
        x = '0;
        for (int i = 0; i < c + 3; i++) x ^= f[i];
        if (f[c+3] == x) cm = 1;
        else begin he = 1; ec = 2; end
    endtask
    initial begin
        logic o_wr, o_cm, o_er;
        int nwr, cm, he, len, cnt, addr;
        logic [1:0] ec;
        tbl[0] = '{96'hA50003102030A6, 7, 3, 1, 0, 2'd0, 16'h0010};
        tbl[1] = '{96'hA50003102030A7, 7, 3, 0, 1, 2'd2, 16'h0010};
        tbl[2] = '{96'h3CA5000155F1,   6, 0, 0, 1, 2'd0, 16'h0000};
        tbl[3] = '{96'hA50003102030A6, 7, 3, 1, 0, 2'd0, 16'h0010};
        tbl[4] = '{96'hA53E021122AA,   6, 2, 1, 0, 2'd0, 16'h3E11};
        tbl[5] = '{96'hA53F02112200,   6, 0, 0, 1, 2'd1, 16'h0000};
        tbl[6] = '{96'hA5000011,       4, 0, 0, 1, 2'd1, 16'h0000};
        tbl[7] = '{96'hA50004AABB,     5, 2, 0, 1, 2'd3, 16'h00AA};
        tbl[8] = '{96'hA5014001,       4, 0, 0, 1, 2'd1, 16'h0000};
        tbl[9] = '{96'hA5,             1, 0, 0, 1, 2'd3, 16'h0000};
        repeat (2) @(negedge clk);
        chk("reset_outs", {wr_en, wr_addr, wr_data, commit, frame_err, err_code, busy}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < tbl[t].len; i++) fb[i] = tbl[t].bytes[8*(tbl[t].len-1-i) +: 8];
            run_frame(fb, tbl[t].len);
            check_frame($sformatf("tbl%0d", t), tbl[t].nwr, tbl[t].cm, tbl[t].he, tbl[t].ec);
            if (tbl[t].nwr > 0) chk($sformatf("tbl%0d.w0", t), got_q.size() > 0 ? {16'h0, got_q[0]} : 32'hFFFF_FFFF, {16'h0, tbl[t].w0});
        end
        // Response latency: write and commit land exactly one cycle after their byte
        open_frame();
        send_byte(8'hA5, o_wr, o_cm, o_er);
        chk("lat.busy", busy, 1);
        send_byte(8'h00, o_wr, o_cm, o_er);
        send_byte(8'h01, o_wr, o_cm, o_er);
        send_byte(8'h5A, o_wr, o_cm, o_er);
        chk("lat.wr", {o_wr, o_cm, wr_data}, {2'b10, 8'h5A});
        send_byte(8'hFE, o_wr, o_cm, o_er);
        chk("lat.commit", {o_wr, o_cm, o_er}, 3'b010);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        // CSUM byte arrives in the very cycle the synchronised deselect rises
        open_frame();
        send_byte(8'hA5, o_wr, o_cm, o_er);
        send_byte(8'h00, o_wr, o_cm, o_er);
        send_byte(8'h01, o_wr, o_cm, o_er);
        send_byte(8'h5A, o_wr, o_cm, o_er);
        ss = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'hFE, o_wr, o_cm, o_er);
        chk("ssedge.commit", {o_cm, o_er}, 2'b10);
        repeat (4) @(negedge clk);
        chk("ssedge.busy", busy, 0);
        // Asynchronous reset in the middle of the data phase
        open_frame();
        send_byte(8'hA5, o_wr, o_cm, o_er);
        send_byte(8'h00, o_wr, o_cm, o_er);
        send_byte(8'h04, o_wr, o_cm, o_er);
        send_byte(8'h01, o_wr, o_cm, o_er);
        send_byte(8'h02, o_wr, o_cm, o_er);
        chk("rst.pre", {wr_en, busy}, 2'b11);
        #2 rst = 1'b1;
        #1 chk("rst.outs", {wr_en, wr_addr, wr_data, commit, frame_err, err_code, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        ss = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.nocommit", n_commit, 0);
        for (int i = 0; i < tbl[0].len; i++) fb[i] = tbl[0].bytes[8*(tbl[0].len-1-i) +: 8];
        run_frame(fb, tbl[0].len);
        check_frame("rst.next", 3, 1, 0, 2'd0);
        for (int r = 0; r < 40; r++) begin
            cnt = $urandom_range(0, 12);
            addr = ($urandom_range(0, 1) == 1) ? NUM_CH - cnt + $urandom_range(0, 2) - 1 : $urandom_range(0, 70);
            if (addr < 0) addr = 0;
            fb[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hA5;
            fb[1] = 8'(addr);
            fb[2] = 8'(cnt);
            for (int i = 3; i < 20; i++) fb[i] = 8'($urandom);
            fb[cnt+3] = 8'h00;
            for (int i = 0; i < cnt + 3; i++) fb[cnt+3] ^= fb[i];
            if ($urandom_range(0, 4) == 0) fb[cnt+3] ^= 8'(1 << $urandom_range(0, 7));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, cnt + 3) : cnt + 4 + $urandom_range(0, 2);
            model(fb, len, nwr, cm, he, ec);
            run_frame(fb, len);
            check_frame($sformatf("rnd%0d", r), nwr, cm, he, ec);
            for (int i = 0; i < nwr && i < got_q.size(); i++) chk($sformatf("rnd%0d.w%0d", r, i), {16'h0, got_q[i]}, {16'h0, exp_q[i]});
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
